// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch routine: FSM state, 7-segment
// table, Out field layout and the reset/blank display word.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK_ZERO = 7'h40;

  localparam int unsigned OUT_W    = 46;
  localparam int unsigned RED_LSB  = 36;
  localparam int unsigned RED_W    = 10;
  localparam int unsigned GRN_LSB  = 28;
  localparam int unsigned GRN_W    = 8;
  localparam int unsigned HEX3_LSB = 21;
  localparam int unsigned HEX2_LSB = 14;
  localparam int unsigned HEX1_LSB = 7;
  localparam int unsigned HEX0_LSB = 0;
  localparam int unsigned HEX_W    = 7;

  localparam logic [OUT_W-1:0] OUT_RESET =
    {18'd0, SEG_BLANK_ZERO, SEG_BLANK_ZERO, SEG_BLANK_ZERO, SEG_BLANK_ZERO};

  // Active-low segments, bit0=a .. bit6=g; non-BCD codes show all segments off.
  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = 7'h7f;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Pushbutton conditioner: 2-flop synchronizer plus falling-edge detect,
// producing a registered 1-cycle press pulse 3 cycles after the pin falls.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      s3    <= 1'b1;
      pulse <= 1'b0;
    end else begin
      s1    <= key;
      s2    <= s1;
      s3    <= s2;
      pulse <= s3 & ~s2;
    end
  end

endmodule

// File: rtl/stopwatch_routine.sv
// Stopwatch: start/stop/clear FSM, 0.01 s prescaler, BCD ss.hh counter with
// 8-bit minutes, registered display word. Lap freeze under `STOPWATCH_LAP_EN.
module stopwatch_routine
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              KeyStart,
  input  logic              KeyClear,
  input  logic              KeyLap,
  output logic [OUT_W-1:0]  Out
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    h0, h1, s0, s1;
  logic [7:0]    minutes;
  logic          start_p, clear_p;
  logic          lap_q;
  logic          tick;

  key_edge u_start (.clk(Clock), .rst(Reset), .key(KeyStart), .pulse(start_p));
  key_edge u_clear (.clk(Clock), .rst(Reset), .key(KeyClear), .pulse(clear_p));

`ifdef STOPWATCH_LAP_EN
  logic lap_p;

  key_edge u_lap (.clk(Clock), .rst(Reset), .key(KeyLap), .pulse(lap_p));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      lap_q <= 1'b0;
    else if (clear_p)
      lap_q <= 1'b0;
    else if (lap_p && state == RUN)
      lap_q <= ~lap_q;
  end
`else
  logic lap_key_unused;
  assign lap_key_unused = KeyLap;
  assign lap_q          = 1'b0;
`endif

  assign tick = (state == RUN) && (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      presc   <= '0;
      h0      <= '0;
      h1      <= '0;
      s0      <= '0;
      s1      <= '0;
      minutes <= '0;
    end else if (clear_p) begin
      state   <= IDLE;
      presc   <= '0;
      h0      <= '0;
      h1      <= '0;
      s0      <= '0;
      s1      <= '0;
      minutes <= '0;
    end else begin
      case (state)
        IDLE:    if (start_p) state <= RUN;
        RUN:     if (start_p) state <= STOP;
        STOP:    if (start_p) state <= RUN;
        default: state <= IDLE;
      endcase

      if (state == RUN)
        presc <= tick ? '0 : presc + PW'(1);

      // A tick coinciding with a start pulse still advances the count.
      if (tick) begin
        if (h0 == 4'd9) begin
          h0 <= 4'd0;
          if (h1 == 4'd9) begin
            h1 <= 4'd0;
            if (s0 == 4'd9) begin
              s0 <= 4'd0;
              if (s1 == 4'd5) begin
                s1      <= 4'd0;
                minutes <= minutes + 8'd1;
              end else begin
                s1 <= s1 + 4'd1;
              end
            end else begin
              s0 <= s0 + 4'd1;
            end
          end else begin
            h1 <= h1 + 4'd1;
          end
        end else begin
          h0 <= h0 + 4'd1;
        end
      end
    end
  end

  // While lap-frozen the digit and minute fields simply stop reloading.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Out <= OUT_RESET;
    end else begin
      Out[RED_LSB +: RED_W] <= {state == RUN, lap_q, 8'h00};
      if (!lap_q) begin
        Out[GRN_LSB  +: GRN_W] <= minutes;
        Out[HEX3_LSB +: HEX_W] <= seg(s1);
        Out[HEX2_LSB +: HEX_W] <= seg(s0);
        Out[HEX1_LSB +: HEX_W] <= seg(h1);
        Out[HEX0_LSB +: HEX_W] <= seg(h0);
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_routine.sv
// Directed bench for stopwatch_routine at TICK_DIV=4; lap checks follow
// `STOPWATCH_LAP_EN.
module tb_stopwatch_routine;

  logic        clk = 1'b0;
  logic        rst;
  logic        kstart, kclear, klap;
  logic [45:0] out;

  int checks   = 0;
  int failures = 0;

  logic [6:0] segt [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  stopwatch_routine #(.TICK_DIV(4)) dut (
    .Clock   (clk),
    .Reset   (rst),
    .KeyStart(kstart),
    .KeyClear(kclear),
    .KeyLap  (klap),
    .Out     (out)
  );

  function automatic logic [45:0] mk(input logic [9:0] red, input logic [7:0] grn,
                                     input int d3, input int d2, input int d1, input int d0);
    return {red, grn, segt[d3], segt[d2], segt[d1], segt[d0]};
  endfunction

  task automatic chk(input string tag, input logic [45:0] obs, input logic [45:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pins low for one cycle; returns one negedge later.
  task automatic press(input logic s, input logic c, input logic l);
    kstart = ~s;
    kclear = ~c;
    klap   = ~l;
    @(negedge clk);
    kstart = 1'b1;
    kclear = 1'b1;
    klap   = 1'b1;
  endtask

  initial begin
    logic [45:0] rst_word;
    rst_word = mk(10'h000, 8'h00, 0, 0, 0, 0);
    rst = 1'b1; kstart = 1'b1; kclear = 1'b1; klap = 1'b1;
    cyc(3);
    chk("rst_hold", out, rst_word);
    rst = 1'b0;
    cyc(2);
    chk("rst_rel", out, rst_word);

    // start: RUN 4 cycles after press, tick every 4 cycles, shown 1 cycle later
    press(1'b1, 1'b0, 1'b0);
    cyc(404);
    chk("run_1s", out, mk(10'h200, 8'h00, 0, 1, 0, 0));
    cyc(23600);
    chk("min_carry", out, mk(10'h200, 8'h01, 0, 0, 0, 0));

    // stop lands just after tick 6001
    press(1'b1, 1'b0, 1'b0);
    cyc(7);
    chk("stop", out, mk(10'h000, 8'h01, 0, 0, 0, 1));
    cyc(100);
    chk("stop_hold", out, mk(10'h000, 8'h01, 0, 0, 0, 1));
    press(1'b0, 1'b0, 1'b1);
    cyc(7);
    chk("lap_in_stop", out, mk(10'h000, 8'h01, 0, 0, 0, 1));

    // resume: prescaler held at 1, so next tick 3 cycles after RUN
    press(1'b1, 1'b0, 1'b0);
    cyc(6);
    chk("resume_pre", out, mk(10'h200, 8'h01, 0, 0, 0, 1));
    cyc(1);
    chk("resume_tick", out, mk(10'h200, 8'h01, 0, 0, 0, 2));

    // clear beats simultaneous start
    press(1'b1, 1'b1, 1'b0);
    cyc(4);
    chk("clr_start", out, mk(10'h000, 8'h00, 0, 0, 0, 0));
    cyc(20);
    chk("clr_idle", out, mk(10'h000, 8'h00, 0, 0, 0, 0));

    // stop pulse coincides with tick 3
    press(1'b1, 1'b0, 1'b0);
    cyc(11);
    press(1'b1, 1'b0, 1'b0);
    cyc(4);
    chk("tick_stop", out, mk(10'h000, 8'h00, 0, 0, 0, 3));
    cyc(20);
    chk("tick_stop_hold", out, mk(10'h000, 8'h00, 0, 0, 0, 3));

    // reset mid-count
    press(1'b1, 1'b0, 1'b0);
    cyc(20);
    rst = 1'b1;
    #1;
    chk("rst_mid", out, rst_word);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("rst_mid_rel", out, rst_word);

    // held start key gives one pulse only
    kstart = 1'b0;
    cyc(50);
    chk("held", out, mk(10'h200, 8'h00, 0, 0, 1, 1));
    kstart = 1'b1;
    press(1'b0, 1'b0, 1'b1);
    cyc(43);
`ifdef STOPWATCH_LAP_EN
    chk("lap_freeze", out, mk(10'h300, 8'h00, 0, 0, 1, 2));
`else
    chk("lap_freeze", out, mk(10'h200, 8'h00, 0, 0, 2, 2));
`endif
    press(1'b0, 1'b0, 1'b1);
    cyc(5);
    chk("lap_release", out, mk(10'h200, 8'h00, 0, 0, 2, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
